// File: rtl/i2c_slave_regbank_if.sv
// Local-side view of the I2C register bank: register contents, write strobe and busy flag.
interface i2c_slave_regbank_if;
  logic [31:0] regs_o;
  logic        wr_stb_o;
  logic [1:0]  wr_idx_o;
  logic        busy_o;

  modport slave  (output regs_o, wr_stb_o, wr_idx_o, busy_o);
  modport master (input  regs_o, wr_stb_o, wr_idx_o, busy_o);
endinterface

// File: rtl/i2c_slave_regbank.sv
// I2C target with a four-byte register bank; open-drain SDA, no clock stretching.
// Pointer byte follows the address on writes; reads start at the current pointer.
module i2c_slave_regbank #(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
  input  logic pclk,
  input  logic presetn,
  input  logic scl,
  inout  wire  sda,
  i2c_slave_regbank_if.slave lb
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK} state_t;

  state_t          state, state_n;
  logic [2:0]      scl_s, sda_s;
  logic [2:0]      cnt, cnt_n;
  logic [7:0]      sh, sh_n, byte_in;
  logic [1:0]      ptr, ptr_n, wr_idx, idx_n;
  logic [3:0][7:0] regs, regs_n;
  logic            sda_oe, sda_oe_n, busy, busy_n, rw, rw_n, mack, mack_n, stb, stb_n;
  logic            scl_rise, scl_fall, start, stop;

  // [0],[1] synchronize; [2] is the delayed copy used for edge detection
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      scl_s <= '1;
      sda_s <= '1;
    end else begin
      scl_s <= {scl_s[1:0], scl};
      sda_s <= {sda_s[1:0], sda};
    end

  assign scl_rise = scl_s[1] & ~scl_s[2];
  assign scl_fall = ~scl_s[1] & scl_s[2];
  assign start    = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
  assign stop     = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
  assign byte_in  = {sh[6:0], sda_s[1]};

  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state  <= IDLE;
      cnt    <= 3'd7;
      sh     <= '0;
      ptr    <= '0;
      regs   <= RST_VAL;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
      rw     <= 1'b0;
      mack   <= 1'b0;
      stb    <= 1'b0;
      wr_idx <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      ptr    <= ptr_n;
      regs   <= regs_n;
      sda_oe <= sda_oe_n;
      busy   <= busy_n;
      rw     <= rw_n;
      mack   <= mack_n;
      stb    <= stb_n;
      wr_idx <= idx_n;
    end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_n     = sh;
    ptr_n    = ptr;
    regs_n   = regs;
    sda_oe_n = sda_oe;
    busy_n   = busy;
    rw_n     = rw;
    mack_n   = mack;
    stb_n    = 1'b0;
    idx_n    = wr_idx;
    if (stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start) begin
      state_n  = ADDR;
      sda_oe_n = 1'b0;
      cnt_n    = 3'd7;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR, PTR, WDATA: if (scl_rise) begin
          sh_n  = byte_in;
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd0) begin
            cnt_n = 3'd7;
            if (state == ADDR) begin
              if (byte_in[7:1] == SLV_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = byte_in[0];
              end else begin
                state_n = IDLE;
                busy_n  = 1'b0;
              end
            end else if (state == PTR) begin
              ptr_n   = byte_in[1:0];
              state_n = PTR_ACK;
            end else begin
              regs_n[ptr] = byte_in;
              stb_n       = 1'b1;
              idx_n       = ptr;
              ptr_n       = ptr + 2'd1;
              state_n     = WACK;
            end
          end
        end
        // First fall after the 8th bit asserts ACK, the next one ends it
        ADDR_ACK, PTR_ACK, WACK: if (scl_fall) begin
          if (!sda_oe) sda_oe_n = 1'b1;
          else begin
            sda_oe_n = 1'b0;
            cnt_n    = 3'd7;
            if (state == ADDR_ACK && rw) begin
              sh_n     = regs[ptr];
              sda_oe_n = ~regs[ptr][7];
              state_n  = RDATA;
            end else if (state == ADDR_ACK) state_n = PTR;
            else                            state_n = WDATA;
          end
        end
        RDATA: if (scl_fall) begin
          if (cnt == 3'd0) begin
            sda_oe_n = 1'b0;
            ptr_n    = ptr + 2'd1;
            mack_n   = 1'b0;
            state_n  = RACK;
          end else begin
            sh_n     = {sh[6:0], 1'b0};
            sda_oe_n = ~sh[6];
            cnt_n    = cnt - 3'd1;
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (sda_s[1]) begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end else mack_n = 1'b1;
          end else if (scl_fall && mack) begin
            mack_n   = 1'b0;
            sh_n     = regs[ptr];
            sda_oe_n = ~regs[ptr][7];
            cnt_n    = 3'd7;
            state_n  = RDATA;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign sda         = sda_oe ? 1'b0 : 1'bz;
  assign lb.regs_o   = regs;
  assign lb.wr_stb_o = stb;
  assign lb.wr_idx_o = wr_idx;
  assign lb.busy_o   = busy;
endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
- I2C target controller attached to the slave side of the two-wire I2C channel; the channel provides the pull-ups and wired-AND resolution.
- Decodes I2C write and read transactions and stores data in four 8-bit registers.
- Presents those registers and write strobes to local logic in the system clock domain.
- Releases SDA only by open-drain behaviour: it drives 0 or high-Z, never 1.
- Does not clock-stretch; it never drives SCL.

Parameters:
- SLV_ADDR, 7'h50, 7-bit I2C target address that this block acknowledges.
- RST_VAL, 32'h0000_0000, reset contents of the register bank; byte n is bits [8n+7:8n].

Ports:
- pclk  input  1  system clock; must run at least 10x the SCL frequency.
- presetn  input  1  asynchronous active-low reset.
- scl  input  1  I2C clock from the channel slave port; sampled only, never driven.
- sda  inout  1  I2C data to the channel slave port; driven as (sda_oe ? 1'b0 : 1'bz).
- regs_o  output  32  register bank; byte n is register n.
- wr_stb_o  output  1  one-pclk pulse when a register is written over I2C.
- wr_idx_o  output  2  index of the register written; valid while wr_stb_o=1.
- busy_o  output  1  high from an address-matched START until STOP, NACK-idle or mismatch.

Behaviour:
- Reset (async assert, sync-deasserted use):
  - regs_o=RST_VAL, sda_oe=0, wr_stb_o=0, wr_idx_o=0, busy_o=0.
  - Register pointer ptr=0, state=IDLE.
  - Synchronizer flops preset to 1.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer, followed by a delayed copy for edge detection.
  - SCL rise/fall and START/STOP are detected on the synchronized signals, so total latency is 3 pclk.
  - START = SDA 1->0 while SCL=1. STOP = SDA 0->1 while SCL=1.
- Bit timing:
  - SDA is sampled on the SCL rising-edge detect.
  - sda_oe changes only on the SCL falling-edge detect, so SDA is stable throughout SCL high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK.
  - IDLE: a START loads bit counter=7 and goes to ADDR. All other SCL activity is ignored.
  - ADDR: shifts in 8 bits, MSB first.
    - If {addr[7:1]}==SLV_ADDR, go to ADDR_ACK and set busy_o=1.
    - Otherwise go to IDLE with SDA released.
  - ADDR_ACK: drive sda_oe=1 for the 9th clock.
    - If R/W=0, go to PTR.
    - If R/W=1, load the shifter with regs[ptr] and go to RDATA. Bit 7 is presented on the same SCL fall that releases ACK.
  - PTR: shift 8 bits; ptr <= byte[1:0] (upper bits ignored). Go to PTR_ACK (ACK driven), then WDATA.
  - WDATA: shift 8 bits, then regs[ptr] <= byte.
    - wr_stb_o=1 for exactly one pclk with wr_idx_o=ptr.
    - ptr <= ptr+1, wrapping 3->0.
    - Go to WACK (ACK driven), then WDATA.
  - RDATA: drive sda_oe=~bit for each bit, MSB first. After bit 0, release SDA and go to RACK; ptr <= ptr+1, wrapping.
  - RACK: sample the master's bit on SCL rise.
    - 0 (ACK): reload regs[ptr] and go to RDATA.
    - 1 (NACK): go to IDLE, busy_o=0, SDA released.
- Overrides from any state:
  - STOP: state=IDLE, sda_oe=0, busy_o=0. A partial byte is discarded and no write occurs.
  - START (repeated start): state=ADDR, sda_oe=0, bit counter=7. ptr is preserved, so write-pointer-then-read-with-repeated-start works.
  - START/STOP take priority over a coincident SCL edge detect.
- Simultaneous events:
  - A local read of regs_o in the same cycle as an I2C write returns the old value; the new value appears the next pclk.
- Reset mid-transfer: SDA is released immediately (asynchronous), so the bus is never held low.

Test Plan:
- Reset with RST_VAL=32'hA5A5_0F0F, no bus activity -> regs_o=32'hA5A5_0F0F, sda high-Z, busy_o=0, wr_stb_o=0.
- START, 0xA0, 0x01, 0x11, 0x22, 0x33, 0x44, STOP ->
  - ACK on all 6 bytes.
  - regs_o=32'h3322_1144; the write to index 0 wraps.
  - 4 wr_stb_o pulses with idx 1,2,3,0.
- START, 0xA0, 0x02, repeated START, 0xA1, master ACK, ACK, NACK, STOP (bank = 32'h3322_1144) ->
  - Returned bytes 0x22, 0x33, 0x44.
  - SDA released after NACK; busy_o=0 after NACK.
- START, 0xA2 (address 7'h51) ->
  - No ACK; SDA stays high-Z through the 9th clock.
  - Subsequent bytes are ignored; regs_o unchanged; busy_o stays 0.
- STOP injected after 4 bits of a data byte -> state IDLE, no wr_stb_o, regs_o unchanged, SDA released.
- presetn pulsed low while the block drives ACK -> SDA goes high-Z within the reset assertion, not on a clock edge; regs_o=RST_VAL.
